// File: rtl/msp430_per_master_pkg.sv
// Shared types and lane-steering helpers for the peripheral bus master.
// Holds the command opcode and FSM state encodings plus byte-lane functions.
// Pure declarations; no clocked logic lives here.
package msp430_per_master_pkg;

  typedef enum logic [1:0] {
    OP_READ    = 2'd0,
    OP_WRITE   = 2'd1,
    OP_RMW_SET = 2'd2,
    OP_RMW_CLR = 2'd3
  } cmd_op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RD   = 2'd1,
    S_WR   = 2'd2,
    S_RESP = 2'd3
  } state_e;

  // Byte write enables for an access: word writes both lanes, byte writes one.
  function automatic logic [1:0] wr_lane(input logic is_byte, input logic odd);
    if (!is_byte) return 2'b11;
    if (odd)      return 2'b10;
    return 2'b01;
  endfunction

  // Place write data on the lane selected by the byte address; unused lane is zero.
  function automatic logic [15:0] wr_steer(input logic is_byte, input logic odd,
                                           input logic [15:0] val);
    if (!is_byte) return val;
    if (odd)      return {val[7:0], 8'h00};
    return {8'h00, val[7:0]};
  endfunction

  // Pull the addressed byte down to the low lane for byte reads.
  function automatic logic [15:0] rd_extract(input logic is_byte, input logic odd,
                                             input logic [15:0] dout);
    if (!is_byte) return dout;
    if (odd)      return {8'h00, dout[15:8]};
    return {8'h00, dout[7:0]};
  endfunction

endpackage

// File: rtl/msp430_per_master.sv
// Command-driven master for the MSP430 peripheral bus: read, write, RMW, bursts.
// Latency: per_en at T+1 after accept; response at T+2 (read/write) or T+3 (RMW).
// Backpressure: one response beat at a time; no bus access while a beat is unaccepted.
module msp430_per_master
  import msp430_per_master_pkg::*;
(
  input  logic        mclk,
  input  logic        puc_rst_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_op,
  input  logic [14:0] cmd_addr,
  input  logic        cmd_byte,
  input  logic [3:0]  cmd_len,
  input  logic [15:0] cmd_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [15:0] rsp_rdata,
  output logic        rsp_last,
  output logic [13:0] per_addr,
  output logic [15:0] per_din,
  output logic        per_en,
  output logic [1:0]  per_we,
  input  logic [15:0] per_dout
);

  state_e      state_q, state_d;
  cmd_op_e     op_q, op_d;
  logic [14:0] addr_q, addr_d;
  logic        byte_q, byte_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [15:0] wdata_q, wdata_d;
  logic        per_en_q, per_en_d;
  logic [1:0]  per_we_q, per_we_d;
  logic [13:0] per_addr_q, per_addr_d;
  logic [15:0] per_din_q, per_din_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [15:0] rsp_rdata_q, rsp_rdata_d;
  logic        rsp_last_q, rsp_last_d;

  // Access launch request, shared by command accept and burst continuation.
  logic        start;
  logic [14:0] st_addr;
  cmd_op_e     st_op;
  logic        st_byte;
  logic [15:0] st_wdata;
  logic [15:0] old_val;
  logic [15:0] mod_val;

  assign cmd_ready = (state_q == S_IDLE) && puc_rst_n;

  // Next-state and registered-output computation for the access sequencer.
  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    addr_d      = addr_q;
    byte_d      = byte_q;
    cnt_d       = cnt_q;
    wdata_d     = wdata_q;
    per_en_d    = 1'b0;
    per_we_d    = per_we_q;
    per_addr_d  = per_addr_q;
    per_din_d   = per_din_q;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_last_d  = rsp_last_q;
    start       = 1'b0;
    st_addr     = addr_q;
    st_op       = op_q;
    st_byte     = byte_q;
    st_wdata    = wdata_q;
    old_val     = rd_extract(byte_q, addr_q[0], per_dout);
    mod_val     = (op_q == OP_RMW_SET) ? (old_val | wdata_q) : (old_val & ~wdata_q);

    case (state_q)
      S_IDLE: begin
        if (cmd_valid && cmd_ready) begin
          start    = 1'b1;
          st_addr  = cmd_addr;
          st_op    = cmd_op_e'(cmd_op);
          st_byte  = cmd_byte;
          st_wdata = cmd_wdata;
          op_d     = cmd_op_e'(cmd_op);
          byte_d   = cmd_byte;
          wdata_d  = cmd_wdata;
          cnt_d    = cmd_len;
        end
      end
      S_RD: begin
        // per_dout is valid in this cycle; RMW keeps the old value for its response.
        per_we_d    = 2'b00;
        rsp_rdata_d = old_val;
        if (op_q == OP_READ) begin
          rsp_valid_d = 1'b1;
          rsp_last_d  = (cnt_q == 4'd0);
          state_d     = S_RESP;
        end else begin
          per_en_d  = 1'b1;
          per_we_d  = wr_lane(byte_q, addr_q[0]);
          per_din_d = wr_steer(byte_q, addr_q[0], mod_val);
          state_d   = S_WR;
        end
      end
      S_WR: begin
        per_we_d    = 2'b00;
        rsp_valid_d = 1'b1;
        rsp_last_d  = (cnt_q == 4'd0);
        if (op_q == OP_WRITE) rsp_rdata_d = 16'h0000;
        state_d     = S_RESP;
      end
      S_RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          if (rsp_last_q) begin
            state_d = S_IDLE;
          end else begin
            start   = 1'b1;
            st_addr = addr_q + (byte_q ? 15'd1 : 15'd2);
            cnt_d   = cnt_q - 4'd1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (start) begin
      addr_d     = st_addr;
      per_en_d   = 1'b1;
      per_addr_d = st_addr[14:1];
      if (st_op == OP_WRITE) begin
        state_d   = S_WR;
        per_we_d  = wr_lane(st_byte, st_addr[0]);
        per_din_d = wr_steer(st_byte, st_addr[0], st_wdata);
      end else begin
        state_d  = S_RD;
        per_we_d = 2'b00;
      end
    end
  end

  // State and output registers with synchronous reset that abandons any access.
  always_ff @(posedge mclk) begin
    if (!puc_rst_n) begin
      state_q     <= S_IDLE;
      op_q        <= OP_READ;
      addr_q      <= 15'd0;
      byte_q      <= 1'b0;
      cnt_q       <= 4'd0;
      wdata_q     <= 16'h0000;
      per_en_q    <= 1'b0;
      per_we_q    <= 2'b00;
      per_addr_q  <= 14'd0;
      per_din_q   <= 16'h0000;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 16'h0000;
      rsp_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      addr_q      <= addr_d;
      byte_q      <= byte_d;
      cnt_q       <= cnt_d;
      wdata_q     <= wdata_d;
      per_en_q    <= per_en_d;
      per_we_q    <= per_we_d;
      per_addr_q  <= per_addr_d;
      per_din_q   <= per_din_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_last_q  <= rsp_last_d;
    end
  end

  assign per_en    = per_en_q;
  assign per_we    = per_we_q;
  assign per_addr  = per_addr_q;
  assign per_din   = per_din_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_last  = rsp_last_q;

endmodule
